// File: rtl/serial_parity_unit.sv
// Serial-to-parallel parity accumulator: assembles FRAME_LEN bits MSB-first and hands
// the word plus its even parity downstream. Define PARITY_CHECK_EN to append a received parity bit per frame.
module serial_parity_unit #(
  parameter int FRAME_LEN = 8,
  parameter int CNT_W     = $clog2(FRAME_LEN + 2)
) (
  input  logic                 clk_i,
  input  logic                 rst_ni,
  input  logic                 bit_i,
  input  logic                 valid_i,
  output logic                 ready_o,
  input  logic                 abort_i,
  output logic [FRAME_LEN-1:0] data_o,
  output logic                 parity_o,
  output logic                 err_o,
  output logic                 valid_o,
  input  logic                 ready_i
);

  // state   | meaning
  // COLLECT | shifting in serial beats, ready_o high once out of reset
  // HOLD    | frame presented on data_o/parity_o, waiting for ready_i
  typedef enum logic {COLLECT = 1'b0, HOLD = 1'b1} state_t;

`ifdef PARITY_CHECK_EN
  localparam int LAST = FRAME_LEN + 1;
`else
  localparam int LAST = FRAME_LEN;
`endif

  state_t               state_q, state_d;
  logic                 init_q;
  logic [CNT_W-1:0]     cnt_q;
  logic [FRAME_LEN-1:0] sr_q;
  logic                 acc_q;
  logic [FRAME_LEN-1:0] data_q;
  logic                 parity_q;
  logic                 accept;
  logic                 last_beat;
  logic                 data_beat;
  logic                 xfer;

  assign accept    = valid_i && ready_o && !abort_i;
  assign last_beat = accept && (cnt_q == CNT_W'(LAST - 1));
  assign xfer      = valid_o && ready_i && !abort_i;

`ifdef PARITY_CHECK_EN
  // the trailing received parity beat never enters the shift register
  assign data_beat = accept && (cnt_q < CNT_W'(FRAME_LEN));
`else
  assign data_beat = accept;
`endif

  // init_q holds ready_o low until the first edge after reset release
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q <= COLLECT;
      init_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      init_q  <= 1'b1;
    end
  end

  always_comb begin
    state_d = state_q;
    if (abort_i) begin
      state_d = COLLECT;
    end else begin
      case (state_q)
        COLLECT: if (last_beat) state_d = HOLD;
        HOLD:    if (ready_i)   state_d = COLLECT;
        default: state_d = COLLECT;
      endcase
    end
  end

  always_comb begin
    ready_o = init_q && (state_q == COLLECT);
    valid_o = (state_q == HOLD);
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      cnt_q <= '0;
      sr_q  <= '0;
      acc_q <= 1'b0;
    end else if (abort_i || xfer) begin
      cnt_q <= '0;
      sr_q  <= '0;
      acc_q <= 1'b0;
    end else if (accept) begin
      cnt_q <= cnt_q + CNT_W'(1);
      if (data_beat) begin
        sr_q  <= {sr_q[FRAME_LEN-2:0], bit_i};
        acc_q <= acc_q ^ bit_i;
      end
    end
  end

`ifdef PARITY_CHECK_EN
  logic err_q;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      data_q   <= '0;
      parity_q <= 1'b0;
      err_q    <= 1'b0;
    end else if (last_beat) begin
      data_q   <= sr_q;
      parity_q <= acc_q;
      err_q    <= bit_i ^ acc_q;
    end
  end

  assign err_o = err_q;
`else
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      data_q   <= '0;
      parity_q <= 1'b0;
    end else if (last_beat) begin
      data_q   <= {sr_q[FRAME_LEN-2:0], bit_i};
      parity_q <= acc_q ^ bit_i;
    end
  end

  assign err_o = 1'b0;
`endif

  assign data_o   = data_q;
  assign parity_o = parity_q;

endmodule

// File: tb/tb_serial_parity_unit.sv
// Scoreboard bench for serial_parity_unit (FRAME_LEN=8); covers PARITY_CHECK_EN when defined.
module tb_serial_parity_unit;

  logic       clk_i = 1'b0;
  logic       rst_ni = 1'b0;
  logic       bit_i = 1'b0;
  logic       valid_i = 1'b0;
  logic       ready_o;
  logic       abort_i = 1'b0;
  logic [7:0] data_o;
  logic       parity_o;
  logic       err_o;
  logic       valid_o;
  logic       ready_i = 1'b1;

  int total = 0;
  int bad = 0;
  logic [9:0] exp_q[$];
  logic [9:0] e;

  serial_parity_unit #(.FRAME_LEN(8)) dut (
    .clk_i(clk_i), .rst_ni(rst_ni), .bit_i(bit_i), .valid_i(valid_i),
    .ready_o(ready_o), .abort_i(abort_i), .data_o(data_o), .parity_o(parity_o),
    .err_o(err_o), .valid_o(valid_o), .ready_i(ready_i)
  );

  always #5 clk_i = ~clk_i;

`ifdef PARITY_CHECK_EN
  localparam int NBEATS = 9;
  localparam bit CHECK = 1'b1;
`else
  localparam int NBEATS = 8;
  localparam bit CHECK = 1'b0;
`endif

  // Drives one frame (data bits then, in check mode, pb) and pushes its expected result.
  // Returns at the negedge following the edge that accepts the final beat.
  task automatic drive_frame(input logic [7:0] d, input logic pb, input int gap);
    logic p;
    p = ^d;
    exp_q.push_back({d, p, CHECK ? (pb ^ p) : 1'b0});
    for (int i = 0; i < NBEATS; i++) begin
      @(negedge clk_i);
      bit_i   = (i < 8) ? d[7-i] : pb;
      valid_i = 1'b1;
      if (i != NBEATS - 1) begin
        for (int g = 0; g < gap; g++) begin
          @(negedge clk_i);
          valid_i = 1'b0;
          bit_i   = 1'($urandom_range(0, 1));
        end
      end
    end
    @(negedge clk_i);
    valid_i = 1'b0;
  endtask

  task automatic test_reset();
    rst_ni = 1'b0;
    repeat (2) @(negedge clk_i);
    total++;
    if ({ready_o, valid_o, data_o, parity_o, err_o} !== 12'h000) begin
      bad++;
      $display("FAIL reset_outputs got rdy=%b vld=%b data=%h par=%b err=%b want all 0",
               ready_o, valid_o, data_o, parity_o, err_o);
    end
    rst_ni = 1'b1;
    #1;
    total++;
    if (ready_o !== 1'b0) begin bad++; $display("FAIL ready_before_edge got %b want 0", ready_o); end
    @(negedge clk_i);
    total++;
    if (ready_o !== 1'b1) begin bad++; $display("FAIL ready_after_release got %b want 1", ready_o); end
  endtask

  task automatic test_basic();
    ready_i = 1'b1;
    drive_frame(8'hB1, 1'b0, 0);
    total++;
    if (valid_o !== 1'b1) begin bad++; $display("FAIL basic_valid_rise got %b want 1", valid_o); end
    e = exp_q.pop_front();
    total++;
    if ({data_o, parity_o, err_o} !== e) begin
      bad++; $display("FAIL basic_frame got %h want %h", {data_o, parity_o, err_o}, e);
    end
    @(negedge clk_i);
    total++;
    if (valid_o !== 1'b0 || ready_o !== 1'b1) begin
      bad++; $display("FAIL basic_one_cycle got vld=%b rdy=%b want 0/1", valid_o, ready_o);
    end
  endtask

  task automatic test_stall();
    ready_i = 1'b0;
    drive_frame(8'h07, 1'b1, 0);
    e = exp_q.pop_front();
    for (int k = 0; k < 3; k++) begin
      if (k > 0) @(negedge clk_i);
      total++;
      if (valid_o !== 1'b1 || ready_o !== 1'b0 || {data_o, parity_o, err_o} !== e) begin
        bad++;
        $display("FAIL stall_hold cyc=%0d got vld=%b rdy=%b frame=%h want 1/0/%h",
                 k, valid_o, ready_o, {data_o, parity_o, err_o}, e);
      end
      if (k == 0) begin valid_i = 1'b1; bit_i = 1'b1; end
      if (k == 1) valid_i = 1'b0;
    end
    ready_i = 1'b1;
    @(negedge clk_i);
    total++;
    if (ready_o !== 1'b1 || valid_o !== 1'b0) begin
      bad++; $display("FAIL stall_release got rdy=%b vld=%b want 1/0", ready_o, valid_o);
    end
  endtask

  task automatic test_gapped();
    ready_i = 1'b1;
    drive_frame(8'hFF, 1'b0, 1);
    total++;
    if (valid_o !== 1'b1) begin bad++; $display("FAIL gapped_valid got %b want 1", valid_o); end
    e = exp_q.pop_front();
    total++;
    if ({data_o, parity_o, err_o} !== e) begin
      bad++; $display("FAIL gapped_frame got %h want %h", {data_o, parity_o, err_o}, e);
    end
    @(negedge clk_i);
  endtask

  task automatic test_reset_mid();
    for (int i = 0; i < 5; i++) begin
      @(negedge clk_i);
      bit_i = 1'b1; valid_i = 1'b1;
    end
    @(negedge clk_i);
    valid_i = 1'b0;
    rst_ni = 1'b0;
    #1;
    total++;
    if ({ready_o, valid_o, data_o, parity_o, err_o} !== 12'h000) begin
      bad++;
      $display("FAIL midreset_outputs got rdy=%b vld=%b data=%h par=%b want all 0",
               ready_o, valid_o, data_o, parity_o);
    end
    @(negedge clk_i);
    rst_ni = 1'b1;
    @(negedge clk_i);
    drive_frame(8'hA5, 1'b0, 0);
    e = exp_q.pop_front();
    total++;
    if (valid_o !== 1'b1 || {data_o, parity_o, err_o} !== e) begin
      bad++; $display("FAIL midreset_frame got vld=%b frame=%h want 1/%h",
                      valid_o, {data_o, parity_o, err_o}, e);
    end
    @(negedge clk_i);
  endtask

  task automatic test_abort();
    for (int i = 0; i < 4; i++) begin
      @(negedge clk_i);
      bit_i = 1'b1; valid_i = 1'b1;
      abort_i = (i == 3);
    end
    @(negedge clk_i);
    abort_i = 1'b0; valid_i = 1'b0;
    drive_frame(8'h80, 1'b1, 0);
    e = exp_q.pop_front();
    total++;
    if (valid_o !== 1'b1 || {data_o, parity_o, err_o} !== e) begin
      bad++; $display("FAIL abort_collect got vld=%b frame=%h want 1/%h",
                      valid_o, {data_o, parity_o, err_o}, e);
    end
    @(negedge clk_i);
    // abort while a frame is held with ready_i asserted: the frame must be dropped
    ready_i = 1'b0;
    drive_frame(8'h3C, 1'b0, 0);
    total++;
    if (valid_o !== 1'b1) begin bad++; $display("FAIL abort_hold_pre got %b want 1", valid_o); end
    abort_i = 1'b1; ready_i = 1'b1;
    @(negedge clk_i);
    abort_i = 1'b0;
    void'(exp_q.pop_front());
    total++;
    if (valid_o !== 1'b0 || ready_o !== 1'b1) begin
      bad++; $display("FAIL abort_hold_drop got vld=%b rdy=%b want 0/1", valid_o, ready_o);
    end
  endtask

  task automatic test_parity_check();
    ready_i = 1'b1;
    drive_frame(8'hB1, 1'b1, 0);
    e = exp_q.pop_front();
    total++;
    if (valid_o !== 1'b1 || {data_o, parity_o, err_o} !== e) begin
      bad++; $display("FAIL check_err1 got vld=%b frame=%h want 1/%h",
                      valid_o, {data_o, parity_o, err_o}, e);
    end
    @(negedge clk_i);
    drive_frame(8'hB1, 1'b0, 0);
    e = exp_q.pop_front();
    total++;
    if (valid_o !== 1'b1 || {data_o, parity_o, err_o} !== e) begin
      bad++; $display("FAIL check_err0 got vld=%b frame=%h want 1/%h",
                      valid_o, {data_o, parity_o, err_o}, e);
    end
    @(negedge clk_i);
  endtask

  initial begin
    test_reset();
    test_basic();
    test_stall();
    test_gapped();
    test_reset_mid();
    test_abort();
    if (CHECK) test_parity_check();
    total++;
    if (exp_q.size() != 0) begin
      bad++; $display("FAIL scoreboard_leftover got %0d entries want 0", exp_q.size());
    end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog got timeout want completion");
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/serial_parity_unit.md
# serial_parity_unit

Serial-to-parallel parity accumulator that sits directly downstream of `xor_gate`. It consumes the single-bit `F_o` stream one bit per accepted beat and assembles a fixed-length frame. It then presents the assembled word and its XOR-reduced parity to the next stage over a valid/ready handshake. It is the first clocked stage in the basic-gate chain and gives the XOR output a registered, frame-aligned consumer.

## Interface
- `FRAME_LEN`, default 8: data bits per frame, legal range 2..32.
- `CNT_W`, default `$clog2(FRAME_LEN+2)`: width of the bit counter. Derived; not overridden.

- `clk_i` input 1: single clock; all state updates on the rising edge.
- `rst_ni` input 1: asynchronous, active-low reset. Reset asserts immediately and releases synchronously to `clk_i`.
- `bit_i` input 1: serial data bit, driven by `xor_gate.F_o`.
- `valid_i` input 1: `bit_i` is valid this cycle.
- `ready_o` output 1: unit can accept a bit this cycle.
- `abort_i` input 1: synchronous discard of the current frame.
- `data_o` output FRAME_LEN: assembled frame. The first accepted bit lands in the MSB.
- `parity_o` output 1: XOR of all FRAME_LEN data bits, i.e. even-parity bit.
- `err_o` output 1: parity mismatch flag (see Configuration).
- `valid_o` output 1: `data_o`, `parity_o` and `err_o` are valid.
- `ready_i` input 1: downstream accepts the frame.

## Operation
- Two states:
  - COLLECT: `ready_o`=1, `valid_o`=0.
  - HOLD: `ready_o`=0, `valid_o`=1.
- Input beat accepted when `valid_i && ready_o` at a rising edge. On acceptance:
  - shift register ← `{sr[FRAME_LEN-2:0], bit_i}`;
  - parity accumulator ← `acc ^ bit_i`;
  - counter increments.
- Frame complete when the accepted beat is the last one: count reaches FRAME_LEN, or FRAME_LEN+1 with `PARITY_CHECK_EN`.
  - On that edge: state → HOLD, and the shift register and accumulator are latched into `data_o` and `parity_o`.
- HOLD → COLLECT on the edge where `valid_o && ready_i`. On that edge the counter, shift register and accumulator clear to 0.
- `ready_o` and `valid_o` are decoded from registered state only; no combinational path from `ready_i` or `valid_i`.
- `abort_i`=1 at an edge, in either state:
  - counter, shift register and accumulator clear;
  - state → COLLECT;
  - any pending output frame is dropped.
- `abort_i` has priority over a simultaneous input beat (the bit is discarded) and over a simultaneous output handshake (the frame is not transferred).
- Counter never wraps; it is bounded by frame completion.
- `bit_i` is ignored whenever `ready_o`=0.

## Timing
- Reset values: `ready_o`=0 while `rst_ni`=0 and 1 from the first edge after release. `valid_o`=0, `data_o`=0, `parity_o`=0, `err_o`=0. State COLLECT, counter 0.
- Latency: `valid_o` rises in the cycle after the edge that accepts the final bit.
- Throughput: at most one frame per FRAME_LEN+1 cycles (+1 with check mode); there is no bypass from HOLD into a new frame.
- In HOLD, `data_o`, `parity_o` and `err_o` stay stable until the transfer edge.
- Reset mid-frame: all partial state is lost immediately and asynchronously, with no output pulse.

## Configuration
- `PARITY_CHECK_EN` defined:
  - each frame is FRAME_LEN data bits followed by one received parity bit;
  - the received parity bit is not stored in `data_o`;
  - `err_o` = received bit XOR computed parity, registered with `valid_o`.
- Not defined: frame is FRAME_LEN data bits only, and `err_o` is tied to 0.

## Test plan
- Reset release, then FRAME_LEN=8 bits 1,0,1,1,0,0,0,1 with `valid_i` held high and `ready_i`=1:
  - `valid_o` high for exactly 1 cycle, one cycle after the 8th bit;
  - `data_o`=8'hB1, `parity_o`=0, `err_o`=0.
- Bits 0,0,0,0,0,1,1,1 with `ready_i`=0 for 3 cycles after `valid_o` rises:
  - `data_o`=8'h07, `parity_o`=1, both stable for 3 cycles;
  - `ready_o`=0 throughout, and a `valid_i` pulse with `bit_i`=1 during the stall is ignored;
  - after `ready_i`=1, `ready_o` returns to 1 the next cycle.
- Gapped input: `valid_i` toggled 1/0 across 16 cycles carrying 8'hFF → `data_o`=8'hFF, `parity_o`=0.
- `rst_ni` pulsed low after 5 of 8 bits:
  - outputs are 0 immediately;
  - the next full frame 8'hA5 yields `data_o`=8'hA5, `parity_o`=0 with no residue from the aborted frame.
- `abort_i` asserted in the same cycle as the 4th bit, then 8 bits of 8'h80 → `data_o`=8'h80, `parity_o`=1.
- With `PARITY_CHECK_EN`:
  - 8'hB1 followed by parity bit 1 → `err_o`=1;
  - 8'hB1 followed by parity bit 0 → `err_o`=0, `data_o`=8'hB1.
